dac_frame_sequencer: RTL and testbench

Sequences the quad-DAC command ROM and the 24-bit SPI shift engine. After power-up it issues the two init words (soft reset, LDAC setup) once. It then sends one four-word channel frame (A..D) per accepted update request. Delta values are latched at frame start so all four words of a frame are coherent. It sits between the MEMS scan/delta generator and the SPI master, and owns the command ROM's address and delta inputs.

---
 rtl/dac_seq_pkg.sv | 22 ++
 rtl/dac_frame_sequencer_if.sv | 17 +
 rtl/dac_seq_timer.sv | 18 +
 rtl/dac_frame_sequencer.sv | 121 ++++++++++++
 tb/tb_dac_frame_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: shared types and constants for the DAC frame sequencer.
// The LDAC state is present only when DAC_SEQ_LDAC_EN is defined.
package dac_seq_pkg;
  localparam int WORD_W  = 24;
  localparam int DELTA_W = 8;
  localparam int TIMER_W = 16;
  localparam logic [3:0] ADDR_SOFT_RESET = 4'd0;
  localparam logic [3:0] ADDR_LDAC_SETUP = 4'd1;
  localparam logic [3:0] ADDR_CH_A       = 4'd2;
  localparam logic [3:0] ADDR_CH_D       = 4'd5;
  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_ADDR,
    ST_FETCH,
    ST_SEND,
    ST_WAIT,
    ST_IDLE
`ifdef DAC_SEQ_LDAC_EN
    , ST_LDAC
`endif
  } state_e;
endpackage

// File: rtl/dac_frame_sequencer_if.sv
// dac_frame_sequencer_if: command-ROM and SPI-engine handshake bundle.
interface dac_frame_sequencer_if;
  logic [3:0]                       rom_addr;
  logic [dac_seq_pkg::DELTA_W-1:0]  rom_delta_a, rom_delta_b, rom_delta_c, rom_delta_d;
  logic [dac_seq_pkg::WORD_W-1:0]   rom_data;
  logic                             spi_start;
  logic [dac_seq_pkg::WORD_W-1:0]   spi_data;
  logic                             spi_done;
  modport master (
    output rom_addr, rom_delta_a, rom_delta_b, rom_delta_c, rom_delta_d, spi_start, spi_data,
    input  rom_data, spi_done
  );
  modport slave (
    input  rom_addr, rom_delta_a, rom_delta_b, rom_delta_c, rom_delta_d, spi_start, spi_data,
    output rom_data, spi_done
  );
endinterface

// File: rtl/dac_seq_timer.sv
// dac_seq_timer: loadable down-counter that parks at zero and flags done there.
module dac_seq_timer #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  assign done_o = cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      cnt_q <= RST_VAL;
    else if (load_i) cnt_q <= load_val_i;
    else if (!done_o) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: issues the two init words after power-up, then one A..D frame per request.
// Define DAC_SEQ_LDAC_EN to add a timed ldac_n pulse after each frame.
module dac_frame_sequencer
  import dac_seq_pkg::*;
#(
  parameter int POWERUP_CYCLES = 1000,
  parameter int LDAC_PULSE     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dac_frame_sequencer_if.master    bus,
  input  logic                     update_req,
  input  logic [DELTA_W-1:0]       delta_a,
  input  logic [DELTA_W-1:0]       delta_b,
  input  logic [DELTA_W-1:0]       delta_c,
  input  logic [DELTA_W-1:0]       delta_d,
  output logic                     ldac_n,
  output logic                     ready,
  output logic                     frame_done,
  output logic [7:0]               overrun_cnt
);
  state_e             state_q;
  logic [3:0]         rom_addr_q;
  logic [DELTA_W-1:0] da_q, db_q, dc_q, dd_q;
  logic [WORD_W-1:0]  spi_data_q;
  logic               spi_start_q, init_q, pending_q, ready_q, frame_done_q;
  logic [7:0]         overrun_q;
  logic               tmr_load, tmr_done, req_any;
  assign req_any = update_req | pending_q;
  dac_seq_timer #(.W(TIMER_W), .RST_VAL(TIMER_W'(POWERUP_CYCLES - 1))) u_timer (
    .clk, .rst_n, .load_i(tmr_load), .load_val_i(TIMER_W'(LDAC_PULSE)), .done_o(tmr_done)
  );
`ifdef DAC_SEQ_LDAC_EN
  logic ldac_n_q;
  assign ldac_n   = ldac_n_q;
  assign tmr_load = state_q == ST_WAIT && bus.spi_done && rom_addr_q == ADDR_CH_D;
`else
  assign ldac_n   = 1'b1;
  assign tmr_load = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= ST_POWERUP;
      rom_addr_q   <= '0;
      {da_q, db_q, dc_q, dd_q} <= '0;
      spi_data_q   <= '0;
      spi_start_q  <= 1'b0;
      init_q       <= 1'b0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= '0;
`ifdef DAC_SEQ_LDAC_EN
      ldac_n_q     <= 1'b1;
`endif
    end else begin
      spi_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b0;
      if (update_req && state_q != ST_IDLE) pending_q <= 1'b1;
      // Pending is one deep; every further request is coalesced and counted.
      if (update_req && pending_q && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
      case (state_q)
        ST_POWERUP: if (tmr_done) begin
          rom_addr_q <= ADDR_SOFT_RESET;
          init_q     <= 1'b1;
          state_q    <= ST_FETCH;
        end
        ST_ADDR: begin
          rom_addr_q <= rom_addr_q + 4'd1;
          state_q    <= ST_FETCH;
        end
        ST_FETCH: state_q <= ST_SEND;
        ST_SEND: begin
          spi_data_q  <= bus.rom_data;
          spi_start_q <= 1'b1;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: if (bus.spi_done) begin
          if (init_q && rom_addr_q == ADDR_LDAC_SETUP) begin
            init_q  <= 1'b0;
            ready_q <= !req_any;
            state_q <= ST_IDLE;
          end else if (rom_addr_q == ADDR_CH_D) begin
            frame_done_q <= 1'b1;
`ifdef DAC_SEQ_LDAC_EN
            state_q      <= ST_LDAC;
`else
            ready_q      <= !req_any;
            state_q      <= ST_IDLE;
`endif
          end else state_q <= ST_ADDR;
        end
        ST_IDLE: if (req_any) begin
          // Deltas are captured here so all four words of the frame agree.
          {da_q, db_q, dc_q, dd_q} <= {delta_a, delta_b, delta_c, delta_d};
          rom_addr_q <= ADDR_CH_A;
          pending_q  <= 1'b0;
          state_q    <= ST_FETCH;
        end else ready_q <= 1'b1;
`ifdef DAC_SEQ_LDAC_EN
        ST_LDAC: if (tmr_done) begin
          ldac_n_q <= 1'b1;
          ready_q  <= !req_any;
          state_q  <= ST_IDLE;
        end else ldac_n_q <= 1'b0;
`endif
        default: state_q <= ST_POWERUP;
      endcase
    end
  assign bus.rom_addr    = rom_addr_q;
  assign bus.rom_delta_a = da_q;
  assign bus.rom_delta_b = db_q;
  assign bus.rom_delta_c = dc_q;
  assign bus.rom_delta_d = dd_q;
  assign bus.spi_start   = spi_start_q;
  assign bus.spi_data    = spi_data_q;
  assign ready           = ready_q;
  assign frame_done      = frame_done_q;
  assign overrun_cnt     = overrun_q;
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: scoreboard bench with a registered command-ROM model and a 30-cycle SPI model.
module tb_dac_frame_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, update_req = 1'b0;
  logic [7:0] delta_a = '0, delta_b = '0, delta_c = '0, delta_d = '0;
  logic       ldac_n, ready, frame_done;
  logic [7:0] overrun_cnt;
  int         checks = 0, errors = 0, fd_cnt = 0, spi_cnt = 0, stray_req = 0, stray_ack = 0;
  logic       prev_done = 1'b0;
  logic [23:0] exp_q[$];
`ifdef DAC_SEQ_LDAC_EN
  localparam bit LDAC_ON = 1'b1;
`else
  localparam bit LDAC_ON = 1'b0;
`endif
  always #5 clk = ~clk;
  dac_frame_sequencer_if bus();
  dac_frame_sequencer #(.POWERUP_CYCLES(10), .LDAC_PULSE(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .update_req(update_req),
    .delta_a(delta_a), .delta_b(delta_b), .delta_c(delta_c), .delta_d(delta_d),
    .ldac_n(ldac_n), .ready(ready), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );
  function automatic logic [23:0] rom_word(input logic [3:0] a, input logic [7:0] da, db, dc, dd);
    case (a)
      4'd0: return 24'h280001;
      4'd1: return 24'h373FF0;
      4'd2: return {8'h00, da, 8'h00};
      4'd3: return {8'h01, db, 8'h00};
      4'd4: return {8'h02, dc, 8'h00};
      4'd5: return {8'h13, dd, 8'h00};
      default: return 24'h0;
    endcase
  endfunction
  always @(posedge clk)
    bus.rom_data <= rom_word(bus.rom_addr, bus.rom_delta_a, bus.rom_delta_b, bus.rom_delta_c, bus.rom_delta_d);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    bus.spi_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.spi_done = 1'b0;
      if (!rst_n) spi_cnt = 0;
      else if (bus.spi_start) spi_cnt = 30;
      else if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) bus.spi_done = 1'b1;
      end
      if (stray_req != stray_ack) begin
        bus.spi_done = 1'b1;
        stray_ack = stray_req;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.spi_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spi_unexpected got %h expected none", bus.spi_data);
          end else chk("spi_data", 32'(bus.spi_data), 32'(exp_q.pop_front()));
        end
        if (frame_done) begin
          fd_cnt++;
          chk("frame_done_after_done", 32'(prev_done), 1);
        end
        prev_done = bus.spi_done;
      end
    end
  end
  task automatic wait_start(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.spi_start && n < lim);
  endtask
  task automatic wait_ready(input int lim);
    int n = 0;
    while (!ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("ready_reached", 32'(ready), 1);
  endtask
  task automatic pulse_req();
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask
  task automatic set_deltas(input logic [7:0] a, b, c, d);
    {delta_a, delta_b, delta_c, delta_d} = {a, b, c, d};
  endtask
  initial begin
    int n, fd0;
    logic bad_s, bad_r;
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_rom_delta", 32'({bus.rom_delta_a, bus.rom_delta_b, bus.rom_delta_c, bus.rom_delta_d}), 0);
    chk("rst_spi_start", 32'(bus.spi_start), 0);
    chk("rst_spi_data", 32'(bus.spi_data), 0);
    chk("rst_ldac_n", 32'(ldac_n), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    exp_q.push_back(24'h280001);
    exp_q.push_back(24'h373FF0);
    rst_n = 1'b1;
    wait_start(100, n);
    chk("init_start_latency", n, 12);
    wait_ready(500);
    chk("init_rom_addr", 32'(bus.rom_addr), 1);
    // single frame, deltas changed after start must not leak into it
    set_deltas(8'h12, 8'h34, 8'h56, 8'h78);
    exp_q.push_back(24'h001200); exp_q.push_back(24'h013400);
    exp_q.push_back(24'h025600); exp_q.push_back(24'h137800);
    fd0 = fd_cnt;
    pulse_req();
    chk("ready_drop", 32'(ready), 0);
    chk("frame_rom_addr", 32'(bus.rom_addr), 2);
    wait_start(20, n);
    chk("frame_start_latency", n, 2);
    set_deltas(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    n = 0;
    while (!bus.spi_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(bus.spi_done), 1);
    wait_start(20, n);
    chk("word_gap", n, 4);
    wait_ready(500);
    chk("frame_done_count", fd_cnt - fd0, 1);
    // three requests mid-frame coalesce into one extra frame
    set_deltas(8'h11, 8'h22, 8'h33, 8'h44);
    exp_q.push_back(24'h001100); exp_q.push_back(24'h012200);
    exp_q.push_back(24'h023300); exp_q.push_back(24'h134400);
    fd0 = fd_cnt;
    pulse_req();
    wait_start(20, n);
    repeat (3) begin
      pulse_req();
      @(negedge clk);
    end
    exp_q.push_back(24'h00AA00); exp_q.push_back(24'h01AA00);
    exp_q.push_back(24'h02AA00); exp_q.push_back(24'h13AA00);
    set_deltas(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    wait_ready(1000);
    chk("overrun_cnt", 32'(overrun_cnt), 2);
    chk("overrun_frames", fd_cnt - fd0, 2);
    // ldac_n / ready around frame end
    set_deltas(8'h01, 8'h02, 8'h03, 8'h04);
    exp_q.push_back(24'h000100); exp_q.push_back(24'h010200);
    exp_q.push_back(24'h020300); exp_q.push_back(24'h130400);
    pulse_req();
    n = 0;
    while (!frame_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", 32'(frame_done), 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("ldac_n_window", 32'(ldac_n), 32'(i >= 5 || !LDAC_ON));
      chk("ready_window", 32'(ready), 32'(i >= 5 || !LDAC_ON));
    end
    // stray spi_done in IDLE
    bad_s = 1'b0;
    bad_r = 1'b0;
    stray_req++;
    repeat (6) begin
      @(negedge clk);
      bad_s |= bus.spi_start;
      bad_r |= !ready;
    end
    chk("stray_no_start", 32'(bad_s), 0);
    chk("stray_ready_held", 32'(bad_r), 0);
    chk("stray_rom_addr", 32'(bus.rom_addr), 5);
    // reset while channel B is being sent
    set_deltas(8'h05, 8'h06, 8'h07, 8'h08);
    exp_q.push_back(24'h000500); exp_q.push_back(24'h010600);
    pulse_req();
    wait_start(20, n);
    wait_start(100, n);
    chk("b_start_seen", 32'(bus.spi_start), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_spi_start", 32'(bus.spi_start), 0);
    chk("async_ldac_n", 32'(ldac_n), 1);
    chk("async_rom_addr", 32'(bus.rom_addr), 0);
    chk("async_overrun", 32'(overrun_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(24'h280001);
    exp_q.push_back(24'h373FF0);
    rst_n = 1'b1;
    wait_start(100, n);
    chk("reinit_start_latency", n, 12);
    wait_ready(500);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
